// File: rtl/tms34020_dbus_responder.sv
// TMS34020 local DBUS target: strobe cycles -> req/ack backend port.
// Optional last-read buffer: define TMS34020_DBUS_RDHIT_EN.
module tms34020_dbus_responder #(
    parameter int unsigned MIN_WAIT = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] DBUS_A,
    input  logic [31:0] DBUS_DO,
    input  logic [3:0]  DBUS_BE,
    input  logic [3:0]  DBUS_CODE,
    input  logic        DBUS_RAS,
    input  logic        DBUS_RD,
    input  logic        DBUS_WE,
    output logic [31:0] DBUS_DI,
    output logic        DBUS_RDY,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [26:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BE,
    output logic [3:0]  MEM_CODE,
    output logic        MEM_LOCK,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        BUS_ERR
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;

    localparam logic [3:0] MW = 4'(MIN_WAIT);
    localparam logic [8:0] TO = 9'(TIMEOUT);

    state_t      state_q;
    logic        rd_q;
    logic        we_q;
    logic        drop_q;
    logic        pend_q;
    logic [3:0]  wait_q;
    logic [3:0]  wait_d;
    logic [7:0]  tmo_q;
    logic [26:0] pa_q;
    logic [31:0] pd_q;
    logic [3:0]  pbe_q;
    logic [3:0]  pcode_q;
    logic        plock_q;
    logic        pwe_q;

    logic        start;
    logic        strb;
    logic        gone;
    logic        tmo_hit;
    logic        use_pend;
    logic        launch;
    logic        l_we;
    logic [26:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_be;
    logic [3:0]  l_code;
    logic        l_lock;
    logic        l_hit;
    logic [31:0] hit_data;
    logic        unused_a;

    assign start    = (DBUS_RD & ~rd_q) | (DBUS_WE & ~we_q);
    assign strb     = DBUS_RD | DBUS_WE;
    assign gone     = drop_q | ~strb;
    assign wait_d   = (wait_q == 4'd15) ? wait_q : wait_q + 4'd1;
    assign tmo_hit  = ({1'b0, tmo_q} + 9'd1) == TO;
    assign use_pend = (state_q == DONE) & pend_q;
    assign launch   = ((state_q == IDLE) & start)
                    | ((state_q == DONE) & strb & (pend_q | start));

    // A queued overlap cycle launches from its captured attributes.
    assign l_we    = use_pend ? pwe_q   : DBUS_WE;
    assign l_addr  = use_pend ? pa_q    : DBUS_A[31:5];
    assign l_wdata = use_pend ? pd_q    : DBUS_DO;
    assign l_be    = use_pend ? pbe_q   : DBUS_BE;
    assign l_code  = use_pend ? pcode_q : DBUS_CODE;
    assign l_lock  = use_pend ? plock_q : DBUS_RAS;

    assign unused_a = ^DBUS_A[4:0];

`ifdef TMS34020_DBUS_RDHIT_EN
    logic        hv_q;
    logic [26:0] ha_q;
    logic [31:0] hd_q;
    logic        l_byp;
    logic        cur_byp;
    logic        b_match;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    assign l_byp    = (l_code == 4'b0100) | (l_code == 4'b0101);
    assign cur_byp  = (MEM_CODE == 4'b0100) | (MEM_CODE == 4'b0101);
    assign b_match  = hv_q & (ha_q == l_addr);
    assign l_hit    = ~l_we & ~l_byp & b_match;
    assign hit_data = hd_q;

    // Writes of any code keep the buffer coherent with the backend.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hv_q <= 1'b0;
            ha_q <= '0;
            hd_q <= '0;
        end else if (launch & l_we & b_match) begin
            hd_q <= merge(hd_q, l_wdata, l_be);
        end else if ((state_q == REQ) & MEM_ACK & ~MEM_WE
                     & ~gone & ~cur_byp) begin
            hv_q <= 1'b1;
            ha_q <= MEM_ADDR;
            hd_q <= MEM_RDATA;
        end
    end
`else
    assign l_hit    = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
            drop_q    <= 1'b0;
            pend_q    <= 1'b0;
            wait_q    <= '0;
            tmo_q     <= '0;
            pa_q      <= '0;
            pd_q      <= '0;
            pbe_q     <= '0;
            pcode_q   <= '0;
            plock_q   <= 1'b0;
            pwe_q     <= 1'b0;
            DBUS_DI   <= '0;
            DBUS_RDY  <= 1'b0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_BE    <= '0;
            MEM_CODE  <= '0;
            MEM_LOCK  <= 1'b0;
            BUS_ERR   <= 1'b0;
        end else begin
            rd_q    <= DBUS_RD;
            we_q    <= DBUS_WE;
            BUS_ERR <= 1'b0;
            wait_q  <= wait_d;
            if (launch) begin
                MEM_WE    <= l_we;
                MEM_ADDR  <= l_addr;
                MEM_WDATA <= l_wdata;
                MEM_BE    <= l_be;
                MEM_CODE  <= l_code;
                MEM_LOCK  <= l_lock;
                DBUS_RDY  <= 1'b0;
                wait_q    <= '0;
                tmo_q     <= '0;
                drop_q    <= 1'b0;
                if (use_pend) pend_q <= 1'b0;
                if (l_hit) begin
                    DBUS_DI <= hit_data;
                    state_q <= HOLD;
                end else begin
                    MEM_REQ <= 1'b1;
                    state_q <= REQ;
                end
            end else begin
                if ((state_q == REQ || state_q == HOLD) && start && !pend_q) begin
                    pend_q  <= 1'b1;
                    pa_q    <= DBUS_A[31:5];
                    pd_q    <= DBUS_DO;
                    pbe_q   <= DBUS_BE;
                    pcode_q <= DBUS_CODE;
                    plock_q <= DBUS_RAS;
                    pwe_q   <= DBUS_WE;
                end
                unique case (state_q)
                    IDLE: ;
                    REQ: begin
                        tmo_q <= tmo_q + 8'd1;
                        if (!strb) drop_q <= 1'b1;
                        // An abandoned cycle still runs to the backend.
                        if (MEM_ACK || tmo_hit) begin
                            MEM_REQ <= 1'b0;
                            BUS_ERR <= ~MEM_ACK;
                            if (!MEM_WE && !gone)
                                DBUS_DI <= MEM_ACK ? MEM_RDATA : 32'hFFFF_FFFF;
                            if (gone) begin
                                pend_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                state_q <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (!strb) begin
                            pend_q  <= 1'b0;
                            state_q <= IDLE;
                        end else if (wait_q >= MW) begin
                            DBUS_RDY <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    DONE: begin
                        if (!strb) begin
                            DBUS_RDY <= 1'b0;
                            pend_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tms34020_dbus_responder.sv
// Scoreboard bench for tms34020_dbus_responder: random cycles against a
// reference memory model, plus timeout, RMW, overlap, abort and reset cases.
module tb_tms34020_dbus_responder;

    localparam int TMO = 255;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] DBUS_A;
    logic [31:0] DBUS_DO;
    logic [3:0]  DBUS_BE;
    logic [3:0]  DBUS_CODE;
    logic        DBUS_RAS;
    logic        DBUS_RD;
    logic        DBUS_WE;
    logic [31:0] DBUS_DI;
    logic        DBUS_RDY;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [26:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_BE;
    logic [3:0]  MEM_CODE;
    logic        MEM_LOCK;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        BUS_ERR;

    tms34020_dbus_responder #(.MIN_WAIT(1), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .DBUS_A(DBUS_A), .DBUS_DO(DBUS_DO), .DBUS_BE(DBUS_BE),
        .DBUS_CODE(DBUS_CODE), .DBUS_RAS(DBUS_RAS),
        .DBUS_RD(DBUS_RD), .DBUS_WE(DBUS_WE),
        .DBUS_DI(DBUS_DI), .DBUS_RDY(DBUS_RDY),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE), .MEM_CODE(MEM_CODE),
        .MEM_LOCK(MEM_LOCK), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [26:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [3:0]  code;
        logic        lock;
    } req_t;

    typedef struct {
        logic [31:0] di;
        logic        err;
        int          lat;
        int          st;
    } rdy_t;

    req_t req_q[$];
    rdy_t rdy_q[$];
    logic [31:0] rmem [int];
    logic [31:0] bmem [int];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int rdy_exp = 0;
    int ack_dly = 0;
    bit no_ack = 0;
    logic [31:0] last_di = '0;

`ifdef TMS34020_DBUS_RDHIT_EN
    bit          c_v = 0;
    logic [26:0] c_a = '0;
`endif

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [26:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rget(input logic [26:0] a);
        return rmem.exists(int'(a)) ? rmem[int'(a)] : init_val(a);
    endfunction

    function automatic logic [31:0] bget(input logic [26:0] a);
        return bmem.exists(int'(a)) ? bmem[int'(a)] : init_val(a);
    endfunction

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Backend memory: acks after ack_dly cycles of MEM_REQ.
    initial begin
        int bcnt;
        bcnt = 0;
        MEM_ACK = 1'b0;
        MEM_RDATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            MEM_ACK = 1'b0;
            MEM_RDATA = $urandom;
            if (MEM_REQ && !no_ack) begin
                if (bcnt >= ack_dly) begin
                    MEM_ACK = 1'b1;
                    if (MEM_WE)
                        bmem[int'(MEM_ADDR)] = merge(bget(MEM_ADDR), MEM_WDATA, MEM_BE);
                    else
                        MEM_RDATA = bget(MEM_ADDR);
                    bcnt = 0;
                end else begin
                    bcnt++;
                end
            end else begin
                bcnt = 0;
            end
        end
    end

    // Monitor: compares backend requests and completions to the scoreboard.
    initial begin
        bit   prev_req, prev_rdy, err_flag;
        req_t r;
        rdy_t y;
        prev_req = 0;
        prev_rdy = 0;
        err_flag = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_req = 0;
                prev_rdy = 0;
                err_flag = 0;
            end else begin
                if (BUS_ERR) err_flag = 1;
                if (MEM_REQ && !prev_req) begin
                    chk("req_expected", req_q.size() > 0, 1);
                    if (req_q.size() > 0) begin
                        r = req_q.pop_front();
                        chk("req_addr", MEM_ADDR, r.addr);
                        chk("req_we", MEM_WE, r.we);
                        chk("req_wdata", MEM_WDATA, r.wd);
                        chk("req_be", MEM_BE, r.be);
                        chk("req_code", MEM_CODE, r.code);
                        chk("req_lock", MEM_LOCK, r.lock);
                    end
                end
                if (DBUS_RDY && !prev_rdy) begin
                    rdy_cnt++;
                    chk("rdy_expected", rdy_q.size() > 0, 1);
                    if (rdy_q.size() > 0) begin
                        y = rdy_q.pop_front();
                        chk("rdy_di", DBUS_DI, y.di);
                        chk("rdy_buserr", err_flag, y.err);
                        if (y.lat >= 0) chk("rdy_latency", cyc - y.st, y.lat);
                    end
                    err_flag = 0;
                end
                prev_req = MEM_REQ;
                prev_rdy = DBUS_RDY;
            end
        end
    end

    task automatic push_rdy(input logic [31:0] di, input bit err,
                            input int lat);
        rdy_t y;
        y.di = di;
        y.err = err;
        y.lat = lat;
        y.st = cyc + 1;
        rdy_q.push_back(y);
        rdy_exp++;
    endtask

    // Raise a strobe at the next cycle and record what must follow.
    task automatic issue(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic [3:0] code, input bit ras,
                         input int dly, input bit noack, input bit want);
        req_t r;
        logic [26:0] w;
        bit hit, byp;
        w = a[31:5];
        hit = 0;
        byp = (code == 4'b0100) || (code == 4'b0101);
        @(posedge CLK);
        #1;
        ack_dly = dly;
        no_ack = noack;
        DBUS_A = a;
        DBUS_DO = d;
        DBUS_BE = be;
        DBUS_CODE = code;
        DBUS_RAS = ras;
        if (wr) DBUS_WE = 1'b1;
        else DBUS_RD = 1'b1;
`ifdef TMS34020_DBUS_RDHIT_EN
        hit = !wr && !byp && c_v && (c_a == w);
`endif
        if (!hit) begin
            r = '{addr: w, we: wr, wd: d, be: be, code: code, lock: ras};
            req_q.push_back(r);
        end
        if (wr) begin
            rmem[int'(w)] = merge(rget(w), d, be);
        end else if (want) begin
            last_di = noack ? 32'hFFFF_FFFF : rget(w);
`ifdef TMS34020_DBUS_RDHIT_EN
            if (!hit && !byp && !noack) begin
                c_v = 1;
                c_a = w;
            end
`endif
        end
        if (want)
            push_rdy(last_di, noack, noack ? TMO + 1 : (hit ? 2 : 2 + dly));
    endtask

    task automatic wait_rdy();
        int t;
        t = 0;
        while (rdy_cnt < rdy_exp && t < 600) begin
            @(posedge CLK);
            t++;
        end
        chk("rdy_wait_budget", rdy_cnt >= rdy_exp, 1);
    endtask

    task automatic end_cycle();
        wait_rdy();
        @(posedge CLK);
        #1;
        DBUS_RD = 1'b0;
        DBUS_WE = 1'b0;
        repeat (3) @(posedge CLK);
    endtask

    function automatic logic [3:0] rcode();
        logic [3:0] codes [5];
        codes = '{4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011};
        return codes[$urandom_range(0, 4)];
    endfunction

    initial begin
        req_t r;
        RST_N = 1'b0;
        DBUS_A = '0;
        DBUS_DO = '0;
        DBUS_BE = '0;
        DBUS_CODE = '0;
        DBUS_RAS = 1'b0;
        DBUS_RD = 1'b0;
        DBUS_WE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs",
            {DBUS_DI, DBUS_RDY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
             MEM_BE, MEM_CODE, MEM_LOCK, BUS_ERR}, 0);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);

        bmem[9] = 32'hDEAD_BEEF;
        rmem[9] = 32'hDEAD_BEEF;
        issue(0, 32'h0000_0120, 32'h0, 4'hF, 4'b1000, 0, 3, 0, 1);
        end_cycle();

        issue(1, 32'h0000_0300, 32'h1234_5678, 4'b0011, 4'b1000, 0, 0, 0, 1);
        end_cycle();

        // Read-modify-write: WE rises as RD falls with RAS held.
        issue(0, 32'h0000_05A0, 32'h0, 4'hF, 4'b1000, 1, 1, 0, 1);
        wait_rdy();
        @(posedge CLK);
        #1;
        DBUS_RD = 1'b0;
        DBUS_WE = 1'b1;
        DBUS_DO = 32'hCAFE_F00D;
        DBUS_BE = 4'b1100;
        r = '{addr: 27'h2D, we: 1'b1, wd: 32'hCAFE_F00D, be: 4'b1100,
              code: 4'b1000, lock: 1'b1};
        req_q.push_back(r);
        rmem[45] = merge(rget(27'h2D), 32'hCAFE_F00D, 4'b1100);
        push_rdy(last_di, 0, 2 + 1);
        @(posedge CLK);
        @(negedge CLK);
        chk("rmw_rdy_drop", DBUS_RDY, 0);
        end_cycle();

        issue(0, 32'h0000_07E0, 32'h0, 4'hF, 4'b1001, 0, 0, 1, 1);
        end_cycle();
        no_ack = 0;

        // Strobes abandoned mid-request: backend completes, no RDY.
        issue(0, 32'h0000_0860, 32'h0, 4'hF, 4'b1000, 0, 6, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        DBUS_RD = 1'b0;
        repeat (15) @(posedge CLK);
        chk("drop_no_rdy", rdy_cnt, rdy_exp);
        chk("drop_req_done", MEM_REQ, 0);

        // Overlapping WE edge while the read is still in REQ.
        issue(0, 32'h0000_0A40, 32'h0, 4'hF, 4'b1000, 1, 4, 0, 1);
        repeat (2) @(posedge CLK);
        #1;
        DBUS_WE = 1'b1;
        DBUS_DO = 32'h0BAD_F00D;
        r = '{addr: 27'h52, we: 1'b1, wd: 32'h0BAD_F00D, be: 4'hF,
              code: 4'b1000, lock: 1'b1};
        req_q.push_back(r);
        rmem[82] = 32'h0BAD_F00D;
        push_rdy(last_di, 0, -1);
        end_cycle();

        issue(0, 32'h0000_0040, 32'h0, 4'hF, 4'b1000, 0, 2, 0, 1);
        end_cycle();
        issue(0, 32'h0000_0040, 32'h0, 4'hF, 4'b1000, 0, 2, 0, 1);
        end_cycle();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {27'(16 + $urandom_range(0, 5)), 5'($urandom)};
            issue(1'($urandom), a, $urandom, 4'($urandom), rcode(),
                  1'($urandom), $urandom_range(0, 4), 0, 1);
            end_cycle();
        end

        // Asynchronous reset while a request is outstanding.
        issue(0, 32'h0000_0C20, 32'h5555_AAAA, 4'hF, 4'b1011, 1, 0, 1, 0);
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_outputs",
            {DBUS_DI, DBUS_RDY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
             MEM_BE, MEM_CODE, MEM_LOCK, BUS_ERR}, 0);
        DBUS_RD = 1'b0;
        no_ack = 0;
        last_di = '0;
`ifdef TMS34020_DBUS_RDHIT_EN
        c_v = 0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);

        issue(1, 32'h0000_0C20, 32'h7777_8888, 4'b0101, 4'b1000, 0, 1, 0, 1);
        end_cycle();
        issue(0, 32'h0000_0C20, 32'h0, 4'hF, 4'b1000, 0, 2, 0, 1);
        end_cycle();

        repeat (5) @(posedge CLK);
        chk("req_queue_drained", req_q.size(), 0);
        chk("rdy_queue_drained", rdy_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
